// File: rtl/game_pkg.sv
// Shared game definitions: key codes, retract source selects, controller
// states and the width of the packed game-state word.
package game_pkg;

    localparam int GAME_STATE_W = 134;

    localparam logic [2:0] KEY_UP      = 3'd0;
    localparam logic [2:0] KEY_DOWN    = 3'd1;
    localparam logic [2:0] KEY_LEFT    = 3'd2;
    localparam logic [2:0] KEY_RIGHT   = 3'd3;
    localparam logic [2:0] KEY_UNDO    = 3'd4;
    localparam logic [2:0] KEY_RESTART = 3'd5;

    localparam logic [1:0] SEL_INT  = 2'd0;
    localparam logic [1:0] SEL_MM   = 2'd1;
    localparam logic [1:0] SEL_BM   = 2'd2;
    localparam logic [1:0] SEL_HOLD = 2'd3;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_COMMIT,
        ST_UNDO,
        ST_WIN
    } state_t;

    // Codes 0..3 are the four move directions.
    function automatic logic is_move_key(input logic [2:0] code);
        return (code[2] == 1'b0);
    endfunction

endpackage

// File: rtl/game_tmo_cnt.sv
// Move-engine timeout window. Loaded when a request is issued, counts down
// while waiting; expire_o is high on the last cycle of the window.
module game_tmo_cnt #(
    parameter int TMO_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CNT_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TMO_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: reload on request, otherwise count down to zero and stop.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/game_retract_ctrl.sv
// Retract/undo controller: takes player keys, drives the move engine,
// and tells the retract register which snapshot to load and when.
module game_retract_ctrl #(
    parameter int STEP_W  = 10,
    parameter int TMO_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_valid,
    input  logic [2:0]        key_code,
    output logic              key_ready,
    output logic              move_start,
    output logic [1:0]        move_dir,
    input  logic              move_done,
    input  logic              move_ok,
    input  logic              move_win,
    output logic [1:0]        sel,
    output logic              game_state_en,
    output logic              undo_avail,
    output logic [STEP_W-1:0] steps,
    output logic              won,
    output logic              err
);
    import game_pkg::*;

    state_t            state_q, state_d;
    logic              rst_hold_q;
    logic [1:0]        dir_q, dir_d;
    logic              win_q, win_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic              undo_q, undo_d;
    logic              won_q, won_d;
    logic              err_q, err_d;
    logic [1:0]        sel_q, sel_d;
    logic              en_q, en_d;
    logic              ready_q, ready_d;
    logic              start_q, start_d;
    logic              take;
    logic              tmo_expire;

    game_tmo_cnt #(
        .TMO_CYC (TMO_CYC)
    ) u_tmo (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (state_q == ST_REQ),
        .en_i     (state_q == ST_WAIT),
        .expire_o (tmo_expire)
    );

    assign take = key_valid && ready_q;

    // Next state, then the registered outputs and counters of the state entered.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        win_d   = win_q;
        steps_d = steps_q;
        undo_d  = undo_q;
        won_d   = won_q;
        err_d   = err_q;
        sel_d   = SEL_HOLD;
        en_d    = 1'b0;
        ready_d = 1'b0;
        start_d = 1'b0;

        case (state_q)
            // Right after reset release INIT is held one extra edge so that
            // the load cycle is the first cycle with rst_n high.
            ST_INIT: if (!rst_hold_q) state_d = ST_IDLE;
            ST_IDLE: begin
                if (take) begin
                    if (is_move_key(key_code)) begin
                        dir_d   = key_code[1:0];
                        state_d = ST_REQ;
                    end else if ((key_code == KEY_UNDO) && undo_q) begin
                        state_d = ST_UNDO;
                    end else if (key_code == KEY_RESTART) begin
                        state_d = ST_INIT;
                    end
                end
            end
            ST_REQ:  state_d = ST_WAIT;
            ST_WAIT: begin
                if (move_done) begin
                    win_d   = move_win;
                    state_d = move_ok ? ST_COMMIT : ST_IDLE;
                end else if (tmo_expire) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_COMMIT: state_d = win_q ? ST_WIN : ST_IDLE;
            ST_UNDO:   state_d = ST_IDLE;
            ST_WIN:    if (take && (key_code == KEY_RESTART)) state_d = ST_INIT;
            default:   state_d = ST_INIT;
        endcase

        case (state_d)
            ST_INIT: begin
                sel_d   = SEL_INT;
                en_d    = 1'b1;
                steps_d = '0;
                undo_d  = 1'b0;
                won_d   = 1'b0;
            end
            ST_IDLE: ready_d = 1'b1;
            ST_REQ:  start_d = 1'b1;
            ST_COMMIT: begin
                sel_d   = SEL_MM;
                en_d    = 1'b1;
                undo_d  = 1'b1;
                steps_d = (steps_q == {STEP_W{1'b1}}) ? steps_q : steps_q + STEP_W'(1);
            end
            ST_UNDO: begin
                sel_d   = SEL_BM;
                en_d    = 1'b1;
                undo_d  = 1'b0;
                steps_d = (steps_q == '0) ? steps_q : steps_q - STEP_W'(1);
            end
            ST_WIN: begin
                won_d   = 1'b1;
                ready_d = 1'b1;
            end
            default: ;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            rst_hold_q <= 1'b1;
            dir_q      <= '0;
            win_q      <= 1'b0;
            steps_q    <= '0;
            undo_q     <= 1'b0;
            won_q      <= 1'b0;
            err_q      <= 1'b0;
            sel_q      <= SEL_HOLD;
            en_q       <= 1'b0;
            ready_q    <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_hold_q <= 1'b0;
            dir_q      <= dir_d;
            win_q      <= win_d;
            steps_q    <= steps_d;
            undo_q     <= undo_d;
            won_q      <= won_d;
            err_q      <= err_d;
            sel_q      <= sel_d;
            en_q       <= en_d;
            ready_q    <= ready_d;
            start_q    <= start_d;
        end
    end

    assign key_ready     = ready_q;
    assign move_start    = start_q;
    assign move_dir      = dir_q;
    assign sel           = sel_q;
    assign game_state_en = en_q;
    assign undo_avail    = undo_q;
    assign steps         = steps_q;
    assign won           = won_q;
    assign err           = err_q;

endmodule

// File: tb/tb_game_retract_ctrl.sv
// Bench for game_retract_ctrl: directed scenarios followed by random key /
// engine traffic, compared against a simple game-rules model.
module tb_game_retract_ctrl;

    localparam int STEP_W   = 10;
    localparam int TMO      = 16;
    localparam int STEP_MAX = (1 << STEP_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              key_valid = 1'b0;
    logic [2:0]        key_code = 3'd0;
    logic              key_ready;
    logic              move_start;
    logic [1:0]        move_dir;
    logic              move_done = 1'b0;
    logic              move_ok = 1'b0;
    logic              move_win = 1'b0;
    logic [1:0]        sel;
    logic              game_state_en;
    logic              undo_avail;
    logic [STEP_W-1:0] steps;
    logic              won;
    logic              err;

    game_retract_ctrl #(
        .STEP_W  (STEP_W),
        .TMO_CYC (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .key_ready     (key_ready),
        .move_start    (move_start),
        .move_dir      (move_dir),
        .move_done     (move_done),
        .move_ok       (move_ok),
        .move_win      (move_win),
        .sel           (sel),
        .game_state_en (game_state_en),
        .undo_avail    (undo_avail),
        .steps         (steps),
        .won           (won),
        .err           (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Pulse monitor: counts loads and move requests, remembers their payload.
    int         en_cnt = 0;
    int         st_cnt = 0;
    int         dbl_en = 0;
    logic       prev_en = 1'b0;
    logic [1:0] last_sel = 2'd3;
    logic [1:0] last_dir = 2'd0;
    always @(negedge clk) begin
        if (game_state_en === 1'b1) begin
            en_cnt++;
            last_sel = sel;
            if (prev_en === 1'b1) dbl_en++;
        end
        prev_en = game_state_en;
        if (move_start === 1'b1) begin
            st_cnt++;
            last_dir = move_dir;
        end
    end

    // Game-rules model.
    int m_steps = 0;
    bit m_undo  = 0;
    bit m_won   = 0;
    bit m_err   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One player key from IDLE/WIN, plus the engine reply when a move is issued.
    // d = WAIT cycles before move_done (d >= TMO means the engine stays silent).
    // poke = present another key while waiting (it must be dropped).
    task automatic op(input logic [2:0] code, input int d, input bit ok,
                      input bit win, input bit poke);
        int   en0, st0, exp_en, exp_st;
        logic [1:0] exp_sel;
        bit   is_move;
        en0 = en_cnt;
        st0 = st_cnt;
        exp_en = 0;
        exp_st = 0;
        exp_sel = 2'd3;
        is_move = (code < 3'd4) && !m_won;

        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;

        if (is_move) begin
            exp_st = 1;
            if (d < TMO) begin
                for (int i = 0; i <= d; i++) begin
                    @(negedge clk);
                    key_valid = poke && (i == 0) && (d >= 2);
                    key_code  = 3'd0;
                end
                key_valid = 1'b0;
                move_done = 1'b1;
                move_ok   = ok;
                move_win  = win;
                @(negedge clk);
                move_done = 1'b0;
                move_ok   = 1'b0;
                move_win  = 1'b0;
                if (ok) begin
                    exp_en  = 1;
                    exp_sel = 2'd1;
                    if (m_steps < STEP_MAX) m_steps++;
                    m_undo = 1;
                    if (win) m_won = 1;
                end
            end else begin
                repeat (TMO + 1) @(negedge clk);
                m_err = 1;
                move_done = 1'b1;
                move_ok   = 1'b1;
                @(negedge clk);
                move_done = 1'b0;
                move_ok   = 1'b0;
            end
        end else if (code == 3'd5) begin
            exp_en  = 1;
            exp_sel = 2'd0;
            m_steps = 0;
            m_undo  = 0;
            m_won   = 0;
        end else if ((code == 3'd4) && !m_won && m_undo) begin
            exp_en  = 1;
            exp_sel = 2'd2;
            m_steps = (m_steps > 0) ? m_steps - 1 : 0;
            m_undo  = 0;
        end

        repeat (3) @(negedge clk);
        chk("steps", 32'(steps), 32'(m_steps));
        chk("undo_avail", 32'(undo_avail), 32'(m_undo));
        chk("won", 32'(won), 32'(m_won));
        chk("err", 32'(err), 32'(m_err));
        chk("en_pulses", 32'(en_cnt - en0), 32'(exp_en));
        chk("move_starts", 32'(st_cnt - st0), 32'(exp_st));
        chk("key_ready", 32'(key_ready), 32'd1);
        chk("sel_rest", 32'(sel), 32'd3);
        if (exp_en == 1) chk("sel_of_load", 32'(last_sel), 32'(exp_sel));
        if (is_move) chk("move_dir", 32'(last_dir), 32'(code[1:0]));
    endtask

    initial begin
        int en0;
        logic [2:0] rc;
        int rd;

        // Reset state.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sel", 32'(sel), 32'd3);
        chk("rst_en", 32'(game_state_en), 32'd0);
        chk("rst_start", 32'(move_start), 32'd0);
        chk("rst_dir", 32'(move_dir), 32'd0);
        chk("rst_ready", 32'(key_ready), 32'd0);
        chk("rst_steps", 32'(steps), 32'd0);
        chk("rst_flags", {29'd0, undo_avail, won, err}, 32'd0);

        // First cycle after release is the INIT load.
        rst_n = 1'b1;
        @(negedge clk);
        chk("init_sel", 32'(sel), 32'd0);
        chk("init_en", 32'(game_state_en), 32'd1);
        @(negedge clk);
        chk("idle_sel", 32'(sel), 32'd3);
        chk("idle_en", 32'(game_state_en), 32'd0);
        chk("idle_ready", 32'(key_ready), 32'd1);
        chk("idle_steps", 32'(steps), 32'd0);

        // Move, undo, second undo.
        op(3'd2, 3, 1'b1, 1'b0, 1'b0);
        op(3'd4, 0, 1'b0, 1'b0, 1'b0);
        op(3'd4, 0, 1'b0, 1'b0, 1'b0);

        // Rejected move, winning move, keys ignored in WIN, restart.
        op(3'd1, 1, 1'b0, 1'b0, 1'b0);
        op(3'd3, 0, 1'b1, 1'b1, 1'b0);
        op(3'd0, 0, 1'b1, 1'b0, 1'b0);
        op(3'd4, 0, 1'b0, 1'b0, 1'b0);
        op(3'd5, 0, 1'b0, 1'b0, 1'b0);

        // Silent engine, late done, restart keeps err.
        op(3'd0, TMO, 1'b0, 1'b0, 1'b0);
        op(3'd5, 0, 1'b0, 1'b0, 1'b0);
        op(3'd6, 0, 1'b0, 1'b0, 1'b0);

        // Fill the step counter, then saturate, then a dropped key in WAIT.
        while (m_steps < STEP_MAX) op(3'd1, 0, 1'b1, 1'b0, 1'b0);
        op(3'd2, 0, 1'b1, 1'b0, 1'b0);
        op(3'd1, 4, 1'b1, 1'b0, 1'b1);
        op(3'd4, 0, 1'b0, 1'b0, 1'b0);
        op(3'd5, 0, 1'b0, 1'b0, 1'b0);

        // Random traffic.
        for (int n = 0; n < 200; n++) begin
            rc = 3'($urandom_range(0, 7));
            rd = ($urandom_range(0, 9) == 0) ? TMO + $urandom_range(0, 3) : $urandom_range(0, 8);
            op(rc, rd, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
               $urandom_range(0, 1) == 1);
        end

        // Reset while waiting on the engine: only the INIT load follows.
        en0 = en_cnt;
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 3'd0;
        @(negedge clk);
        key_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_steps = 0; m_undo = 0; m_won = 0; m_err = 0;
        @(negedge clk);
        move_done = 1'b1;
        move_ok   = 1'b1;
        @(negedge clk);
        move_done = 1'b0;
        move_ok   = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_en_pulses", 32'(en_cnt - en0), 32'd1);
        chk("abort_sel", 32'(last_sel), 32'd0);
        chk("abort_steps", 32'(steps), 32'(m_steps));
        chk("abort_err", 32'(err), 32'(m_err));
        chk("abort_ready", 32'(key_ready), 32'd1);

        chk("en_back_to_back", 32'(dbl_en), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
